// File: rtl/aes_pkg.sv
// Shared widths and state encoding for the AES block loader.
// Word 0 of a group lands in the most significant lane.
package aes_pkg;

  localparam int BLOCK_W       = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;
  localparam int IDX_W         = 2;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/aes_word_packer.sv
// Packs four 32-bit words into a 128-bit register, first word in the top lane.
// WRAP=1 keeps accepting and rewrites from lane 0; WRAP=0 stalls once full.
module aes_word_packer
  import aes_pkg::*;
#(
  parameter bit WRAP = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [WORD_W-1:0]  wr_data,
  output logic [BLOCK_W-1:0] blk_nxt,
  output logic               full,
  output logic               full_nxt
);

  logic [BLOCK_W-1:0] blk_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_nxt;
  logic               full_q;
  logic               wr_ok;

  assign wr_ok = wr_en && (WRAP || !full_q);
  assign full  = full_q;

  always_comb begin
    blk_nxt  = blk_q;
    idx_nxt  = idx_q;
    full_nxt = full_q;
    if (clr) begin
      idx_nxt  = '0;
      full_nxt = 1'b0;
    end else if (wr_ok) begin
      for (int i = 0; i < WORDS_PER_BLK; i++) begin
        if (idx_q == IDX_W'(i)) blk_nxt[BLOCK_W-1-i*WORD_W -: WORD_W] = wr_data;
      end
      // Starting a fresh group invalidates the previous complete set.
      if (idx_q == '0) full_nxt = 1'b0;
      if (idx_q == IDX_W'(WORDS_PER_BLK-1)) full_nxt = 1'b1;
      idx_nxt = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q  <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      blk_q  <= blk_nxt;
      idx_q  <= idx_nxt;
      full_q <= full_nxt;
    end
  end

endmodule

// File: rtl/aes_block_loader.sv
// Feeds AES_top: packs key/data words, holds them for one engine run,
// aborts a run on watchdog expiry and counts completed blocks.
//
// state | meaning
// LOAD  | collecting key/data words, engine idle
// RUN   | engine enabled, operands frozen, watchdog counting
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic               AES_clk,
  input  logic               AES_rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_is_key,
  output logic               AES_en,
  output logic [BLOCK_W-1:0] AES_data_in,
  output logic [BLOCK_W-1:0] AES_key_in,
  input  logic               AES_data_out_valid,
  output logic               busy,
  output logic               key_loaded,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   blocks_done
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t             state_q;
  state_t             state_nxt;
  logic [WD_W-1:0]    wd_q;
  logic               run_done;
  logic               run_tmo;
  logic               key_wr;
  logic               dat_wr;
  logic               dat_clr;
  logic               data_full;
  logic               data_full_nxt;
  logic               key_loaded_nxt;
  logic [BLOCK_W-1:0] key_nxt;
  logic [BLOCK_W-1:0] dat_nxt;

  assign s_ready = (state_q == LOAD) && !(data_full && !s_is_key);
  assign key_wr  = s_valid && s_ready && s_is_key;
  assign dat_wr  = s_valid && s_ready && !s_is_key;
  assign dat_clr = run_done || run_tmo;
  assign AES_en  = (state_q == RUN);
  assign busy    = (state_q == RUN);

  aes_word_packer #(.WRAP(1'b1)) u_key_pack (
    .clk      (AES_clk),
    .rst      (AES_rst),
    .clr      (1'b0),
    .wr_en    (key_wr),
    .wr_data  (s_data),
    .blk_nxt  (key_nxt),
    .full     (key_loaded),
    .full_nxt (key_loaded_nxt)
  );

  aes_word_packer #(.WRAP(1'b0)) u_dat_pack (
    .clk      (AES_clk),
    .rst      (AES_rst),
    .clr      (dat_clr),
    .wr_en    (dat_wr),
    .wr_data  (s_data),
    .blk_nxt  (dat_nxt),
    .full     (data_full),
    .full_nxt (data_full_nxt)
  );

  always_comb begin
    state_nxt = state_q;
    run_done  = 1'b0;
    run_tmo   = 1'b0;
    case (state_q)
      LOAD: begin
        // Uses next-cycle flags so the completing word launches the run directly.
        if (data_full_nxt && key_loaded_nxt) state_nxt = RUN;
      end
      RUN: begin
        if (AES_data_out_valid) begin
          run_done  = 1'b1;
          state_nxt = LOAD;
        end else if (wd_q == WD_W'(TIMEOUT-1)) begin
          run_tmo   = 1'b1;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q     <= LOAD;
      wd_q        <= '0;
      AES_data_in <= '0;
      AES_key_in  <= '0;
      timeout_err <= 1'b0;
      blocks_done <= '0;
    end else begin
      state_q     <= state_nxt;
      timeout_err <= run_tmo;
      wd_q        <= (state_q == RUN) ? wd_q + WD_W'(1) : '0;
      if (run_done) blocks_done <= blocks_done + CNT_W'(1);
      if (state_q == LOAD && state_nxt == RUN) begin
        AES_data_in <= dat_nxt;
        AES_key_in  <= key_nxt;
      end
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: directed vectors plus a randomized
// word stream compared against a word-level model of key/data collection.
module tb_aes_block_loader;

  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  logic         AES_clk = 1'b0;
  logic         AES_rst;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_is_key;
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic         AES_data_out_valid;
  logic         busy;
  logic         key_loaded;
  logic         timeout_err;
  logic [CNT_W-1:0] blocks_done;

  aes_block_loader #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .AES_clk            (AES_clk),
    .AES_rst            (AES_rst),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .s_data             (s_data),
    .s_is_key           (s_is_key),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out_valid (AES_data_out_valid),
    .busy               (busy),
    .key_loaded         (key_loaded),
    .timeout_err        (timeout_err),
    .blocks_done        (blocks_done)
  );

  always #5 AES_clk = ~AES_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the words most recently collected, per the loading rules.
  logic [31:0]      mk [4];
  logic [31:0]      md [4];
  int               m_kcnt;
  int               m_dcnt;
  bit               m_loaded;
  logic [CNT_W-1:0] m_blocks;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] exp_key();
    return {mk[0], mk[1], mk[2], mk[3]};
  endfunction

  function automatic logic [127:0] exp_dat();
    return {md[0], md[1], md[2], md[3]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mk[i] = '0;
      md[i] = '0;
    end
    m_kcnt   = 0;
    m_dcnt   = 0;
    m_loaded = 0;
    m_blocks = '0;
  endtask

  function automatic bit m_in_run();
    return (m_dcnt == 4) && m_loaded;
  endfunction

  // Offer one word starting at a negedge; waits up to max_wait extra cycles.
  task automatic send_word(input logic [31:0] w, input bit is_key, input int max_wait,
                           output bit acc);
    int waited;
    s_valid  = 1'b1;
    s_data   = w;
    s_is_key = is_key;
    #1;
    chk("s_ready", s_ready, !(m_dcnt == 4 && !is_key));
    acc    = 0;
    waited = 0;
    forever begin
      if (s_ready === 1'b1) begin
        acc = 1;
        @(negedge AES_clk);
        break;
      end
      if (waited >= max_wait) begin
        @(negedge AES_clk);
        break;
      end
      @(negedge AES_clk);
      #1;
      waited++;
    end
    s_valid = 1'b0;
    if (acc) begin
      if (is_key) begin
        if (m_kcnt == 0) m_loaded = 0;
        mk[m_kcnt] = w;
        if (m_kcnt == 3) begin
          m_loaded = 1;
          m_kcnt   = 0;
        end else begin
          m_kcnt++;
        end
      end else if (m_dcnt < 4) begin
        md[m_dcnt] = w;
        m_dcnt++;
      end
      chk("en_after_accept", AES_en, m_in_run());
      chk("key_loaded", key_loaded, m_loaded);
      if (m_in_run()) begin
        chk("key_snapshot", AES_key_in, exp_key());
        chk("data_snapshot", AES_data_in, exp_dat());
        chk("busy", busy, 1'b1);
      end
    end
  endtask

  // Called at the first negedge of RUN; engine answers in RUN cycle resp.
  task automatic run_block(input int resp);
    int hi;
    bit exp_done;
    exp_done = (resp <= TIMEOUT-1);
    hi = 0;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      if (AES_en !== 1'b1) break;
      hi++;
      AES_data_out_valid = (i == resp);
      @(negedge AES_clk);
    end
    AES_data_out_valid = 1'b0;
    chk("en_high_cycles", hi, exp_done ? resp + 1 : TIMEOUT);
    chk("timeout_err", timeout_err, !exp_done);
    if (exp_done) m_blocks = m_blocks + 1'b1;
    chk("blocks_done", blocks_done, m_blocks);
    chk("key_kept", key_loaded, m_loaded);
    chk("ready_after_run", s_ready, 1'b1);
    m_dcnt = 0;
    if (!exp_done) begin
      @(negedge AES_clk);
      chk("timeout_pulse_width", timeout_err, 1'b0);
    end
  endtask

  task automatic fill_until_run();
    bit acc;
    bit is_key;
    for (int i = 0; i < 16; i++) begin
      if (m_in_run()) break;
      is_key = (m_dcnt == 4) ? 1'b1 : (!m_loaded && $urandom_range(0, 1) == 1);
      send_word($urandom, is_key, 0, acc);
    end
    chk("fill_reached_run", AES_en, 1'b1);
  endtask

  logic [31:0] vec_key [4] = '{32'haa2bdb40, 32'hbff6a5e8, 32'hcaa9ba3e, 32'hbc1e2acc};
  logic [31:0] vec_d1  [4] = '{32'h000000e3, 32'h0, 32'h0, 32'h0};
  logic [31:0] vec_d2  [4] = '{32'ha6f2daeb, 32'h140fa720, 32'h529e75d5, 32'h21cbc681};

  initial begin
    bit acc;
    bit is_key;
    logic [31:0] w5;
    int lat;

    AES_rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_is_key = 1'b0;
    AES_data_out_valid = 1'b0;
    repeat (2) @(negedge AES_clk);
    AES_rst = 1'b0;
    model_reset();
    chk("rst_en", AES_en, 1'b0);
    chk("rst_key_loaded", key_loaded, 1'b0);
    chk("rst_blocks", blocks_done, '0);
    chk("rst_key_in", AES_key_in, '0);
    chk("rst_data_in", AES_data_in, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tmo", timeout_err, 1'b0);

    // Known-answer load
    for (int i = 0; i < 4; i++) send_word(vec_key[i], 1'b1, 0, acc);
    for (int i = 0; i < 4; i++) send_word(vec_d1[i], 1'b0, 0, acc);
    chk("vec_key_in", AES_key_in, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
    chk("vec_data_in", AES_data_in, 128'h000000e3_00000000_00000000_00000000);
    chk("vec_ready_in_run", s_ready, 1'b0);
    run_block(10);
    chk("vec_blocks_one", blocks_done, 16'd1);

    // Second block reuses the key
    for (int i = 0; i < 4; i++) send_word(vec_d2[i], 1'b0, 0, acc);
    chk("reuse_key_in", AES_key_in, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
    chk("reuse_data_in", AES_data_in, 128'ha6f2daeb_140fa720_529e75d5_21cbc681);
    run_block(5);

    // Data full while key incomplete: fifth data word stalls
    send_word($urandom, 1'b1, 0, acc);
    for (int i = 0; i < 4; i++) send_word($urandom, 1'b0, 0, acc);
    w5 = $urandom;
    send_word(w5, 1'b0, 3, acc);
    chk("stall_fifth", acc, 1'b0);
    chk("stall_no_run", AES_en, 1'b0);
    for (int i = 0; i < 3; i++) send_word($urandom, 1'b1, 0, acc);
    run_block(2);
    send_word(w5, 1'b0, 0, acc);
    chk("fifth_after_run", acc, 1'b1);

    // Watchdog abort, then completion on the last allowed cycle
    for (int i = 0; i < 3; i++) send_word($urandom, 1'b0, 0, acc);
    run_block(TIMEOUT + 5);
    for (int i = 0; i < 4; i++) send_word($urandom, 1'b0, 0, acc);
    run_block(TIMEOUT - 1);

    // Randomized word stream
    for (int n = 0; n < 250; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge AES_clk);
      is_key = ($urandom_range(0, 9) < 3);
      if (!is_key && m_dcnt == 4) begin
        send_word($urandom, 1'b0, 2, acc);
        chk("rand_stall", acc, 1'b0);
      end else begin
        send_word($urandom, is_key, 0, acc);
        if (m_in_run()) begin
          lat = ($urandom_range(0, 5) == 0) ? TIMEOUT + $urandom_range(0, 3)
                                            : $urandom_range(0, TIMEOUT - 1);
          run_block(lat);
        end
      end
    end

    // Reset in the middle of a run
    fill_until_run();
    AES_rst = 1'b1;
    @(negedge AES_clk);
    chk("midrun_rst_en", AES_en, 1'b0);
    @(negedge AES_clk);
    AES_rst = 1'b0;
    model_reset();
    chk("midrun_rst_key_loaded", key_loaded, 1'b0);
    chk("midrun_rst_blocks", blocks_done, '0);
    chk("midrun_rst_key_in", AES_key_in, '0);

    // Block counter wrap
    force dut.blocks_done = 16'hFFFF;
    @(negedge AES_clk);
    release dut.blocks_done;
    m_blocks = 16'hFFFF;
    fill_until_run();
    run_block(3);
    chk("wrap_zero", blocks_done, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
